// File: rtl/ofifo_multimode.sv
// Output FIFO for MAC-array partial sums: one circular buffer per column,
// independent per-column writes, and reads either a full row at once
// (parallel) or one column at a time in round-robin order (serial).
module ofifo_multimode #(
  parameter int col   = 8,
  parameter int bw    = 16,
  parameter int depth = 64
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              clr,
  input  logic [col*bw-1:0]                 in,
  input  logic [col-1:0]                    wr,
  input  logic                              rd,
  input  logic                              rd_mode,
  output logic [col*bw-1:0]                 out,
  output logic [((col > 1) ? $clog2(col) : 1)-1:0] out_col,
  output logic                              o_valid,
  output logic                              o_full,
  output logic                              o_empty,
  output logic [$clog2(depth):0]            o_level,
  output logic                              o_overflow,
  output logic                              o_underflow
);

  localparam int aw = $clog2(depth);
  localparam int cw = (col > 1) ? $clog2(col) : 1;

  logic [bw-1:0]     mem [col][depth];
  logic [aw-1:0]     wptr [col];
  logic [aw-1:0]     rptr [col];
  logic [aw:0]       cnt  [col];
  logic [cw-1:0]     colptr;
  logic              mode_q;

  logic [col-1:0]    push;
  logic [col-1:0]    pop;
  logic [col-1:0]    full_vec;
  logic              all_nonempty;
  logic              accept;
  logic [col*bw-1:0] row_word;
  logic [bw-1:0]     ser_word;

  // Status flags and minimum occupancy, all judged on registered counts
  always_comb begin
    o_full       = 1'b0;
    o_empty      = 1'b1;
    all_nonempty = 1'b1;
    o_level      = (aw+1)'(depth);
    full_vec     = '0;
    for (int c = 0; c < col; c++) begin
      full_vec[c] = (cnt[c] == (aw+1)'(depth));
      if (full_vec[c]) o_full = 1'b1;
      if (cnt[c] != '0) o_empty = 1'b0;
      else              all_nonempty = 1'b0;
      if (cnt[c] < o_level) o_level = cnt[c];
    end
    o_valid = mode_q ? (cnt[colptr] != '0) : all_nonempty;
  end

  // Accepted push/pop per column and the words a pop would present
  always_comb begin
    push     = '0;
    pop      = '0;
    row_word = '0;
    accept   = rd && o_valid && !clr;
    for (int c = 0; c < col; c++) begin
      push[c] = wr[c] && !full_vec[c] && !clr;
      pop[c]  = accept && (!mode_q || (colptr == cw'(c)));
      row_word[c*bw +: bw] = mem[c][rptr[c]];
    end
    ser_word = mem[colptr][rptr[colptr]];
  end

  // Storage array, written only by accepted pushes
  always_ff @(posedge clk) begin
    for (int c = 0; c < col; c++) begin
      if (push[c]) mem[c][wptr[c]] <= in[c*bw +: bw];
    end
  end

  // Pointers, counts, read register, round-robin pointer, mode and sticky flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < col; c++) begin
        wptr[c] <= '0;
        rptr[c] <= '0;
        cnt[c]  <= '0;
      end
      out         <= '0;
      out_col     <= '0;
      colptr      <= '0;
      mode_q      <= 1'b0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else if (clr) begin
      for (int c = 0; c < col; c++) begin
        wptr[c] <= '0;
        rptr[c] <= '0;
        cnt[c]  <= '0;
      end
      out         <= '0;
      out_col     <= '0;
      colptr      <= '0;
      mode_q      <= 1'b0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      for (int c = 0; c < col; c++) begin
        if (push[c]) wptr[c] <= wptr[c] + aw'(1);
        if (pop[c])  rptr[c] <= rptr[c] + aw'(1);
        if (push[c] && !pop[c])      cnt[c] <= cnt[c] + (aw+1)'(1);
        else if (pop[c] && !push[c]) cnt[c] <= cnt[c] - (aw+1)'(1);
      end
      if (accept) begin
        if (mode_q) begin
          out     <= (col*bw)'(ser_word);
          out_col <= colptr;
          colptr  <= (colptr == cw'(col-1)) ? '0 : colptr + cw'(1);
        end else begin
          out     <= row_word;
          out_col <= '0;
        end
      end
      if (colptr == '0) mode_q <= rd_mode;
      if (|(wr & full_vec)) o_overflow <= 1'b1;
      if (rd && !o_valid)   o_underflow <= 1'b1;
    end
  end

endmodule

// File: doc/ofifo_multimode.md
Name: ofifo_multimode

Overview:
- Parametrised output FIFO that collects per-column partial sums from the MAC array and presents them to the downstream reader.
- Each column has its own independent write enable and circular buffer.
- Reads run in one of two modes: parallel (a full row of all columns pops at once) or serial (one column per read, round-robin).
- Adds sticky overflow/underflow error flags, an occupancy level output and a synchronous clear.

Parameters:
- col, 8, number of columns/channels.
- bw, 16, data width per column (psum width).
- depth, 64, entries per column; must be a power of two and at least 2; aw = $clog2(depth).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous clear; lower priority than reset.
- in  input  col*bw  write data; column c occupies bits [c*bw +: bw].
- wr  input  col  per-column write enable.
- rd  input  1  read request.
- rd_mode  input  1  0 = parallel row read; 1 = serial column read.
- out  output  col*bw  registered read data.
- out_col  output  $clog2(col)  column index of the last serial pop; 0 in parallel mode.
- o_valid  output  1  a read would be accepted this cycle.
- o_full  output  1  at least one column is full.
- o_empty  output  1  all columns are empty.
- o_level  output  aw+1  minimum occupancy across all columns.
- o_overflow  output  1  sticky: a write was dropped.
- o_underflow  output  1  sticky: a read was rejected.

Behaviour:
- State per column: wptr, rptr (aw bits each) and cnt (aw+1 bits). Globals: colptr ($clog2(col) bits) and mode_q.
- Reset (reset=0, asynchronous): all pointers, counts, out, out_col, colptr, mode_q and both sticky flags are 0.
  - Outputs after reset: o_empty=1, o_full=0, o_valid=0, o_level=0.
  - Reset asserted mid-operation discards all contents immediately.
- clr=1 at an edge: same state as reset, applied synchronously. Writes and reads in that same cycle are ignored.
- Write: column c with wr[c]=1 and cnt_c<depth:
  - mem_c[wptr_c] <= in[c]; wptr_c increments and wraps modulo depth.
  - If wr[c]=1 and cnt_c==depth: the write is dropped and o_overflow is set.
  - Fullness is judged on pre-edge state. A write to a full column is dropped even if the same cycle pops that column.
- Mode latch: mode_q <= rd_mode only at edges where colptr==0. While a serial row is partly drained, a change on rd_mode is ignored until colptr returns to 0.
- Parallel mode (mode_q=0):
  - o_valid = all cnt_c != 0.
  - rd && o_valid: every column pops, out <= {mem_c[rptr_c]}, every rptr increments, out_col <= 0.
- Serial mode (mode_q=1):
  - o_valid = cnt[colptr] != 0.
  - rd && o_valid: only column colptr pops. out <= zero-extended mem_colptr[rptr] in bits [bw-1:0], upper bits 0. out_col <= colptr.
  - colptr increments and wraps to 0 after col-1.
- mode_q used combinationally for o_valid is the currently latched value.
- Read latency: 1 cycle. Popped data appears on out after the accepting edge and holds until the next accepted pop, clr or reset.
- Rejected read: rd=1 with o_valid=0 leaves out, pointers and colptr unchanged and sets o_underflow.
- Counts: cnt_c updates by +1 (write only), -1 (pop only) or 0 (both, or neither). Read and write on the same edge in a non-full column are both accepted.
- Derived outputs:
  - o_full = OR of (cnt_c == depth).
  - o_empty = AND of (cnt_c == 0).
  - o_level = min over c of cnt_c.
  - All are combinational from registered state.
- Sticky flags clear only on reset or clr.

Test Plan:
- Reset/idle: col=8, bw=16, depth=4; hold reset=0 then release -> out=0, o_empty=1, o_valid=0, o_level=0, both flags 0.
- Parallel row: wr=8'hFF with column c data = 16'h0100+c for 2 cycles; rd_mode=0; rd for 2 cycles.
  - out words match per column in FIFO order (second row 16'h0100+c, same values).
  - o_level goes 2 -> 1 -> 0; o_empty=1 at the end.
- Skewed writes: wr=8'h01 only, then rd=1 -> o_valid=0, o_underflow=1, out unchanged. After writing the remaining columns, o_valid=1.
- Overflow: 5 writes with wr=8'h01 at depth=4.
  - Fifth write is dropped; o_full=1, o_overflow=1.
  - Subsequent pops return only the first 4 values in order.
- Serial mode: fill one row with column c = 16'hA0+c; rd_mode=1; rd for 8 cycles.
  - out[15:0] = 16'hA0..16'hA7 and out_col = 0..7 in sequence; upper bits 0.
  - Toggling rd_mode at read 3 has no effect until colptr wraps.
- Simultaneous traffic and clear:
  - Column at cnt=2 with wr and rd on the same edge -> cnt stays 2, data order preserved.
  - Then clr=1 -> o_empty=1 and flags 0 on the next cycle.
